// File: rtl/id_ex_if.sv
// ---------------------------------------------------------------------------
// id_ex_if
// Bundle of every non-clock/reset signal between the decode side, the
// forwarding sources and the ID/EX stage.
//   master : drives the ID fields, stall/flush and the EX/MEM, MEM/WB
//            forwarding sources; observes the ALU operands and EX control
//   slave  : the id_ex_stage itself
// Parameters: XLEN (datapath width), RA_W (register-address width)
// ---------------------------------------------------------------------------
interface id_ex_if #(
    parameter int XLEN = 32,
    parameter int RA_W = 5
);
    logic            id_valid;
    logic [XLEN-1:0] id_pc;
    logic [XLEN-1:0] id_imm;
    logic [XLEN-1:0] id_rs1_data;
    logic [XLEN-1:0] id_rs2_data;
    logic [RA_W-1:0] id_rs1;
    logic [RA_W-1:0] id_rs2;
    logic [RA_W-1:0] id_rd;
    logic [3:0]      id_alu_op;
    logic            id_src_a;
    logic            id_src_b;
    logic            id_reg_write;
    logic            id_mem_read;
    logic            stall;
    logic            flush;
    logic [RA_W-1:0] mem_rd;
    logic            mem_reg_write;
    logic [XLEN-1:0] mem_result;
    logic [RA_W-1:0] wb_rd;
    logic            wb_reg_write;
    logic [XLEN-1:0] wb_data;
    logic [XLEN-1:0] alu_a;
    logic [XLEN-1:0] alu_b;
    logic [3:0]      alu_op;
    logic            ex_valid;
    logic            ex_reg_write;
    logic            ex_mem_read;
    logic [XLEN-1:0] ex_pc;
    logic [RA_W-1:0] ex_rd;
    logic [XLEN-1:0] ex_store_data;
    logic            hazard_stall;

    modport master (
        output id_valid, id_pc, id_imm, id_rs1_data, id_rs2_data,
               id_rs1, id_rs2, id_rd, id_alu_op, id_src_a, id_src_b,
               id_reg_write, id_mem_read, stall, flush,
               mem_rd, mem_reg_write, mem_result,
               wb_rd, wb_reg_write, wb_data,
        input  alu_a, alu_b, alu_op, ex_valid, ex_reg_write, ex_mem_read,
               ex_pc, ex_rd, ex_store_data, hazard_stall
    );

    modport slave (
        input  id_valid, id_pc, id_imm, id_rs1_data, id_rs2_data,
               id_rs1, id_rs2, id_rd, id_alu_op, id_src_a, id_src_b,
               id_reg_write, id_mem_read, stall, flush,
               mem_rd, mem_reg_write, mem_result,
               wb_rd, wb_reg_write, wb_data,
        output alu_a, alu_b, alu_op, ex_valid, ex_reg_write, ex_mem_read,
               ex_pc, ex_rd, ex_store_data, hazard_stall
    );
endinterface

// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
// ID/EX pipeline register plus the operand-select / forwarding front end of
// the execute stage. Drives the ALU operands directly and flags hazards that
// the external hazard unit turns into an IF/ID hold plus a flush of this
// stage.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : id_ex_if.slave (ID fields, stall/flush, forwarding sources in;
//          ALU operands, EX control, store data and hazard_stall out)
// Configuration macro: ID_EX_FORWARDING_EN
//   defined   : EX/MEM and MEM/WB forwarding, hazard_stall on load-use only
//   undefined : no forwarding, hazard_stall on any RAW against EX or MEM
// ---------------------------------------------------------------------------
module id_ex_stage #(
    parameter int XLEN = 32,
    parameter int RA_W = 5
) (
    input logic   clk,
    input logic   rst,
    id_ex_if.slave bus
);
    logic            r_valid;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_imm;
    logic [XLEN-1:0] r_rs1_data;
    logic [XLEN-1:0] r_rs2_data;
    logic [RA_W-1:0] r_rs1;
    logic [RA_W-1:0] r_rs2;
    logic [RA_W-1:0] r_rd;
    logic [3:0]      r_alu_op;
    logic            r_src_a;
    logic            r_src_b;
    logic            r_reg_write;
    logic            r_mem_read;

    logic [XLEN-1:0] w_fwd_rs1;
    logic [XLEN-1:0] w_fwd_rs2;
    logic            w_hazard;

    // Reset and flush both produce a fully zeroed bubble; flush outranks
    // stall so a bubble is written even while the pipe is frozen.
    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            r_valid     <= 1'b0;
            r_pc        <= '0;
            r_imm       <= '0;
            r_rs1_data  <= '0;
            r_rs2_data  <= '0;
            r_rs1       <= '0;
            r_rs2       <= '0;
            r_rd        <= '0;
            r_alu_op    <= 4'd0;
            r_src_a     <= 1'b0;
            r_src_b     <= 1'b0;
            r_reg_write <= 1'b0;
            r_mem_read  <= 1'b0;
        end else if (!bus.stall) begin
            r_valid     <= bus.id_valid;
            r_pc        <= bus.id_pc;
            r_imm       <= bus.id_imm;
            r_rs1_data  <= bus.id_rs1_data;
            r_rs2_data  <= bus.id_rs2_data;
            r_rs1       <= bus.id_rs1;
            r_rs2       <= bus.id_rs2;
            r_rd        <= bus.id_rd;
            r_alu_op    <= bus.id_alu_op;
            r_src_a     <= bus.id_src_a;
            r_src_b     <= bus.id_src_b;
            r_reg_write <= bus.id_reg_write;
            r_mem_read  <= bus.id_mem_read;
        end
    end

`ifdef ID_EX_FORWARDING_EN
    // The younger producer (EX/MEM) wins over MEM/WB; x0 is never forwarded.
    always_comb begin
        w_fwd_rs1 = r_rs1_data;
        if (bus.mem_reg_write && bus.mem_rd == r_rs1 && r_rs1 != '0)
            w_fwd_rs1 = bus.mem_result;
        else if (bus.wb_reg_write && bus.wb_rd == r_rs1 && r_rs1 != '0)
            w_fwd_rs1 = bus.wb_data;
    end

    always_comb begin
        w_fwd_rs2 = r_rs2_data;
        if (bus.mem_reg_write && bus.mem_rd == r_rs2 && r_rs2 != '0)
            w_fwd_rs2 = bus.mem_result;
        else if (bus.wb_reg_write && bus.wb_rd == r_rs2 && r_rs2 != '0)
            w_fwd_rs2 = bus.wb_data;
    end

    // Only a load in EX cannot be forwarded in time. rs2 is compared even
    // when the consumer may not read it, which can cost a spurious bubble.
    always_comb begin
        w_hazard = bus.id_valid && r_valid && r_mem_read && r_rd != '0 &&
                   (r_rd == bus.id_rs1 || r_rd == bus.id_rs2);
    end
`else
    // Without forwarding the operands come straight from the register file
    // snapshot; WB needs no check because the register file writes through.
    always_comb begin
        w_fwd_rs1 = r_rs1_data;
        w_fwd_rs2 = r_rs2_data;
    end

    always_comb begin
        w_hazard = bus.id_valid && (
            (bus.id_rs1 != '0 &&
                ((r_valid && r_reg_write && r_rd == bus.id_rs1) ||
                 (bus.mem_reg_write && bus.mem_rd == bus.id_rs1))) ||
            (bus.id_rs2 != '0 &&
                ((r_valid && r_reg_write && r_rd == bus.id_rs2) ||
                 (bus.mem_reg_write && bus.mem_rd == bus.id_rs2))));
    end

    logic w_unused_nofwd;
    assign w_unused_nofwd = ^{bus.mem_result, bus.wb_rd, bus.wb_reg_write,
                              bus.wb_data, r_rs1, r_rs2};
`endif

    assign bus.alu_a         = r_src_a ? r_pc  : w_fwd_rs1;
    assign bus.alu_b         = r_src_b ? r_imm : w_fwd_rs2;
    assign bus.ex_store_data = w_fwd_rs2;
    assign bus.alu_op        = r_alu_op;
    assign bus.ex_valid      = r_valid;
    assign bus.ex_reg_write  = r_reg_write & r_valid;
    assign bus.ex_mem_read   = r_mem_read & r_valid;
    assign bus.ex_pc         = r_pc;
    assign bus.ex_rd         = r_rd;
    assign bus.hazard_stall  = w_hazard;

endmodule

// File: tb/tb_id_ex_stage.sv
// ---------------------------------------------------------------------------
// tb_id_ex_stage
// Directed bench for id_ex_stage. The stimulus process pushes hand-computed
// expected outputs into a queue; the monitor pops one entry per falling edge
// and compares it against the DUT. Expectations that differ between the
// forwarding and non-forwarding builds are selected on ID_EX_FORWARDING_EN.
// ---------------------------------------------------------------------------
module tb_id_ex_stage;

`ifdef ID_EX_FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    typedef struct {
        string       name;
        logic        valid;
        logic        regw;
        logic        memr;
        logic [3:0]  op;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [31:0] aluA;
        logic [31:0] aluB;
        logic [31:0] store;
        logic        haz;
    } expT;

    logic clk;
    logic rst;
    int   compared;
    int   mismatched;
    expT  scoreboard[$];

    id_ex_if #(.XLEN(32), .RA_W(5)) bus ();

    id_ex_stage #(.XLEN(32), .RA_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] pc,
                                 input logic [31:0] imm, input logic [4:0] rs1,
                                 input logic [31:0] rs1d, input logic [4:0] rs2,
                                 input logic [31:0] rs2d, input logic [4:0] rd,
                                 input logic [3:0] op, input logic sa,
                                 input logic sb, input logic rw, input logic mr);
        bus.id_valid     = v;
        bus.id_pc        = pc;
        bus.id_imm       = imm;
        bus.id_rs1       = rs1;
        bus.id_rs1_data  = rs1d;
        bus.id_rs2       = rs2;
        bus.id_rs2_data  = rs2d;
        bus.id_rd        = rd;
        bus.id_alu_op    = op;
        bus.id_src_a     = sa;
        bus.id_src_b     = sb;
        bus.id_reg_write = rw;
        bus.id_mem_read  = mr;
    endtask

    task automatic idleId();
        applyStimulus(1'b0, 32'h0, 32'h0, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0,
                      4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic setFwd(input logic [4:0] mrd, input logic mrw,
                          input logic [31:0] mres, input logic [4:0] wrd,
                          input logic wrw, input logic [31:0] wdat);
        bus.mem_rd        = mrd;
        bus.mem_reg_write = mrw;
        bus.mem_result    = mres;
        bus.wb_rd         = wrd;
        bus.wb_reg_write  = wrw;
        bus.wb_data       = wdat;
    endtask

    task automatic pushExp(input string name, input logic v, input logic rw,
                           input logic mr, input logic [3:0] op,
                           input logic [31:0] pc, input logic [4:0] rd,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] st, input logic hz);
        expT e;
        e.name = name; e.valid = v; e.regw = rw; e.memr = mr; e.op = op;
        e.pc = pc; e.rd = rd; e.aluA = a; e.aluB = b; e.store = st; e.haz = hz;
        scoreboard.push_back(e);
    endtask

    task automatic pushZero(input string name, input logic hz);
        pushExp(name, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0, 5'd0, 32'h0, 32'h0,
                32'h0, hz);
    endtask

    task automatic cmp(input string name, input string field,
                       input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s.%s: got 0x%08h, expected 0x%08h",
                     name, field, act, exp);
        end
    endtask

    task automatic checkOutput(input expT e);
        cmp(e.name, "ex_valid",      32'(bus.ex_valid),      32'(e.valid));
        cmp(e.name, "ex_reg_write",  32'(bus.ex_reg_write),  32'(e.regw));
        cmp(e.name, "ex_mem_read",   32'(bus.ex_mem_read),   32'(e.memr));
        cmp(e.name, "alu_op",        32'(bus.alu_op),        32'(e.op));
        cmp(e.name, "ex_pc",         bus.ex_pc,              e.pc);
        cmp(e.name, "ex_rd",         32'(bus.ex_rd),         32'(e.rd));
        cmp(e.name, "alu_a",         bus.alu_a,              e.aluA);
        cmp(e.name, "alu_b",         bus.alu_b,              e.aluB);
        cmp(e.name, "ex_store_data", bus.ex_store_data,      e.store);
        cmp(e.name, "hazard_stall",  32'(bus.hazard_stall),  32'(e.haz));
    endtask

    // Monitor: one expectation per cycle, sampled on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (scoreboard.size() > 0) begin
                expT e;
                e = scoreboard.pop_front();
                checkOutput(e);
            end
        end
    end

    initial begin
        compared   = 0;
        mismatched = 0;
        rst        = 1'b1;
        bus.stall  = 1'b0;
        bus.flush  = 1'b0;
        idleId();
        setFwd(5'd0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0);

        // Reset held for two edges, then one idle load
        tick();
        tick();
        pushZero("reset", 1'b0);
        rst = 1'b0;
        tick();
        pushZero("idle", 1'b0);

        // EX/MEM vs MEM/WB forwarding priority on rs1 = x5
        applyStimulus(1'b1, 32'h40, 32'h4, 5'd5, 32'h11, 5'd6, 32'h66, 5'd8,
                      4'h3, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        bus.stall = 1'b1;
        idleId();
        setFwd(5'd5, 1'b1, 32'h22, 5'd5, 1'b1, 32'h33);
        pushExp("fwd_mem", 1'b1, 1'b1, 1'b0, 4'h3, 32'h40, 5'd8,
                FWD ? 32'h22 : 32'h11, 32'h66, 32'h66, 1'b0);
        tick();
        bus.mem_reg_write = 1'b0;
        pushExp("fwd_wb", 1'b1, 1'b1, 1'b0, 4'h3, 32'h40, 5'd8,
                FWD ? 32'h33 : 32'h11, 32'h66, 32'h66, 1'b0);
        tick();

        // Stall for three cycles with new ID data: EX must hold
        applyStimulus(1'b1, 32'h200, 32'h20, 5'd9, 32'h99, 5'd10, 32'hAA,
                      5'd10, 4'h5, 1'b1, 1'b1, 1'b1, 1'b1);
        setFwd(5'd0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            pushExp("stall_hold", 1'b1, 1'b1, 1'b0, 4'h3, 32'h40, 5'd8,
                    32'h11, 32'h66, 32'h66, 1'b0);
            tick();
        end

        // Flush together with stall writes the bubble
        bus.flush = 1'b1;
        tick();
        pushZero("flush_over_stall", 1'b0);
        bus.stall = 1'b0;
        bus.flush = 1'b0;

        // x0 is never a forwarding target
        applyStimulus(1'b1, 32'h80, 32'h8, 5'd3, 32'h31, 5'd0, 32'h0, 5'd4,
                      4'h1, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        bus.stall = 1'b1;
        idleId();
        setFwd(5'd0, 1'b1, 32'hDEAD, 5'd0, 1'b1, 32'hBEEF);
        pushExp("x0_guard", 1'b1, 1'b1, 1'b0, 4'h1, 32'h80, 5'd4,
                32'h31, 32'h0, 32'h0, 1'b0);
        tick();
        bus.stall = 1'b0;

        // Load to x7 followed by a consumer of x7
        applyStimulus(1'b1, 32'hC0, 32'h10, 5'd1, 32'h1000, 5'd0, 32'h0, 5'd7,
                      4'h0, 1'b0, 1'b1, 1'b1, 1'b1);
        setFwd(5'd0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0);
        tick();
        applyStimulus(1'b1, 32'hC4, 32'h0, 5'd2, 32'h222, 5'd7, 32'h700, 5'd9,
                      4'h2, 1'b0, 1'b0, 1'b1, 1'b0);
        pushExp("load_use", 1'b1, 1'b1, 1'b1, 4'h0, 32'hC0, 5'd7,
                32'h1000, 32'h10, 32'h0, 1'b1);
        bus.flush = 1'b1;
        tick();
        pushZero("load_use_bubble", 1'b0);
        tick();
        setFwd(5'd7, 1'b1, 32'h77, 5'd0, 1'b0, 32'h0);
        pushZero("mem_raw", FWD ? 1'b0 : 1'b1);
        bus.flush = 1'b0;
        tick();
        idleId();
        setFwd(5'd0, 1'b0, 32'h0, 5'd7, 1'b1, 32'h1234);
        pushExp("wb_fwd_rs2", 1'b1, 1'b1, 1'b0, 4'h2, 32'hC4, 5'd9,
                32'h222, FWD ? 32'h1234 : 32'h700, FWD ? 32'h1234 : 32'h700,
                1'b0);
        tick();

        // PC/immediate select; store data still follows forwarded rs2
        applyStimulus(1'b1, 32'h100, 32'hFFFFFFFC, 5'd1, 32'hAA, 5'd2, 32'hBB,
                      5'd3, 4'hA, 1'b1, 1'b1, 1'b1, 1'b0);
        setFwd(5'd0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0);
        tick();
        applyStimulus(1'b1, 32'h104, 32'h0, 5'd3, 32'h0, 5'd0, 32'h0, 5'd5,
                      4'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        setFwd(5'd2, 1'b1, 32'h5555, 5'd0, 1'b0, 32'h0);
        pushExp("pc_imm_sel", 1'b1, 1'b1, 1'b0, 4'hA, 32'h100, 5'd3,
                32'h100, 32'hFFFFFFFC, FWD ? 32'h5555 : 32'hBB,
                FWD ? 1'b0 : 1'b1);
        tick();

        // Reset in the middle of an in-flight instruction
        rst = 1'b1;
        setFwd(5'd0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0);
        tick();
        pushZero("mid_reset", 1'b0);
        tick();
        rst = 1'b0;
        idleId();

        for (int i = 0; i < 5 && scoreboard.size() > 0; i++)
            @(negedge clk);
        if (scoreboard.size() > 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL drain: %0d entries left, expected 0",
                     scoreboard.size());
        end
        #2;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register and operand-select/forwarding front end of the execute stage. It latches decoded fields from ID and resolves RAW hazards by forwarding from the EX/MEM and MEM/WB stages. It drives the ALU's `a`, `b` and `alu_op` directly, and flags the hazards that the hazard unit must convert into an IF/ID stall.

## Interface
- `XLEN`, 32, datapath width
- `RA_W`, 5, register-address width

- `clk` in 1: clock, rising edge
- `rst` in 1: synchronous, active-high reset
- `id_valid` in 1: ID holds a real instruction
- `id_pc`, `id_imm`, `id_rs1_data`, `id_rs2_data` in XLEN: decoded PC, immediate, register-file read data
- `id_rs1`, `id_rs2`, `id_rd` in RA_W: register addresses
- `id_alu_op` in 4: ALU operation code
- `id_src_a` in 1: 0 = rs1, 1 = PC
- `id_src_b` in 1: 0 = rs2, 1 = imm
- `id_reg_write`, `id_mem_read` in 1: writeback enable, load flag
- `stall` in 1: global freeze; downstream stages are frozen in the same cycle
- `flush` in 1: insert a bubble
- `mem_rd` in RA_W, `mem_reg_write` in 1, `mem_result` in XLEN: EX/MEM forwarding source
- `wb_rd` in RA_W, `wb_reg_write` in 1, `wb_data` in XLEN: MEM/WB forwarding source
- `alu_a`, `alu_b` out XLEN: ALU operands
- `alu_op` out 4: registered operation code
- `ex_valid`, `ex_reg_write`, `ex_mem_read` out 1: registered control
- `ex_pc` out XLEN, `ex_rd` out RA_W: registered PC and destination
- `ex_store_data` out XLEN: forwarded rs2 value, independent of `id_src_b`
- `hazard_stall` out 1: ID must hold and EX receives a bubble

## Operation
- Register priority per rising edge: `rst` > `flush` > `stall` > load.
- Load: capture every `id_*` field; `ex_valid` <= `id_valid`.
- Flush: `ex_valid`, `ex_reg_write` and `ex_mem_read` are set to 0; the other fields are don't-care (implementation zeroes them).
- Stall: all registers hold.
- Effective write enables: `ex_reg_write` and `ex_mem_read` outputs are the registered values ANDed with `ex_valid`.
- Forwarding for rs1 uses registered `ex_rs1`, checked in priority order:
  - `mem_reg_write && mem_rd == ex_rs1 && ex_rs1 != 0` → `mem_result`
  - else `wb_reg_write && wb_rd == ex_rs1 && ex_rs1 != 0` → `wb_data`
  - else the registered `rs1_data`
- rs2 forwarding uses the same rule. The forwarded rs2 drives `ex_store_data`.
- Operand select:
  - `alu_a` = `src_a` ? `ex_pc` : forwarded rs1
  - `alu_b` = `src_b` ? `ex_imm` : forwarded rs2
- Register x0 is never a forwarding target and never causes a hazard.
- `hazard_stall`, forwarding build (load-use only): `ex_valid && ex_mem_read && ex_rd != 0 && (ex_rd == id_rs1 || ex_rd == id_rs2)`, gated by `id_valid`.
- The external hazard unit responds to `hazard_stall` by asserting `flush` to this block and holding IF/ID. This block does not self-flush.
- `hazard_stall` is conservative: it does not know whether the instruction actually uses rs2.

## Timing
- Register fields update on the rising edge. Reset value of every registered output is 0, including `alu_op` = 4'd0 and `ex_pc` = 0.
- `alu_a`, `alu_b`, `ex_store_data` and `hazard_stall` are combinational from registered state and same-cycle `mem_*`/`wb_*`/`id_*` inputs. No added latency: the ALU result is valid in the same cycle.
- Latency ID→EX is 1 cycle. A load followed by a dependent instruction costs exactly 1 bubble.
- Simultaneous `flush` and `stall`: flush wins, and the bubble is written.
- `rst` mid-operation clears the in-flight instruction on that edge. `hazard_stall` is 0 in the cycle after reset.
- During `stall` the forwarding sources are frozen too, so the forwarded operands stay stable.

## Configuration
- `ID_EX_FORWARDING_EN` defined: forwarding as above; `hazard_stall` covers load-use only.
- Undefined:
  - No forwarding muxes; `alu_a`/`alu_b`/`ex_store_data` use the registered register-file data.
  - `hazard_stall` asserts whenever `id_valid` and a nonzero `id_rs1` or `id_rs2` matches `ex_rd` (with `ex_valid && ex_reg_write`) or `mem_rd` (with `mem_reg_write`).
  - The register file is write-through, so WB needs no stall.
  - `mem_result`, `wb_*` and `wb_data` are unused.

## Test plan
- Reset then idle: after `rst` high for 2 cycles → all outputs 0, `ex_valid` = 0, `hazard_stall` = 0.
- EX/MEM forward: EX holds rs1 = x5 with `rs1_data` = 0x11; `mem_rd` = 5, `mem_reg_write` = 1, `mem_result` = 0x22; `wb_rd` = 5, `wb_data` = 0x33 → `alu_a` = 0x22. With `mem_reg_write` = 0 → 0x33.
- x0 guard: `ex_rs2` = 0, `mem_rd` = 0, `mem_result` = 0xDEAD, `src_b` = 0 → `alu_b` = registered `rs2_data` (0), no forwarding.
- Load-use: EX holds a load to x7 (`ex_mem_read` = 1); ID `id_rs2` = 7 → `hazard_stall` = 1. After `flush` for one edge → `ex_valid` = 0 and `hazard_stall` = 0.
- Stall/flush priority: `stall` = 1 for 3 cycles with new ID data → EX fields unchanged. `stall` = 1 and `flush` = 1 together → `ex_valid` = 0 and `ex_reg_write` = 0.
- Immediate/PC select: `id_src_a` = 1, `id_pc` = 0x100, `id_src_b` = 1, `id_imm` = 0xFFFFFFFC → next cycle `alu_a` = 0x100 and `alu_b` = 0xFFFFFFFC. `ex_store_data` still equals forwarded rs2.
